gray_counter_bank: RTL and testbench
====================================

// Module: gray_counter_bank
// PURPOSE
//  Parametrised successor to the single 4-bit gray counter top. Holds NUM_CNT independent
//  binary/gray counters behind one request pipe and one indication pipe. Decodes request
//  messages on-chip, executes inc/dec/read/write per channel and buffers replies in an
//  IND_DEPTH FIFO. Adds error replies and saturating mode. Sits between host portal and funnel.
// PARAMETERS
//  WIDTH      4    counter width, bits (1..32)
//  NUM_CNT    4    number of counters (1..256)
//  IND_DEPTH  4    indication FIFO depth, entries (power of 2, >=2)
//  HDR_W      16   message header width
//  DATA_W     128  message payload width (>=WIDTH)
//  SATURATE   0    0: inc/dec wrap modulo 2^WIDTH; 1: clamp at all-ones / zero
// PORTS
//  CLK                  in   1              sole clock
//  nRST                 in   1              reset: synchronous, active-high (1 = reset)
//  request$enq__ENA     in   1              request beat valid; only asserted while __RDY
//  request$enq$v        in   HDR_W+DATA_W   request message
//  request$enq__RDY     out  1              block can accept a request this cycle
//  indication$enq__ENA  out  1              reply beat transferred this cycle
//  indication$enq$v     out  HDR_W+DATA_W   reply message (FIFO head)
//  indication$enq__RDY  in   1              downstream can take a reply
// BEHAVIOUR
//  Clock/reset: one clock CLK; reset nRST is synchronous and active-high.
//  Message: v[DATA_W+15:DATA_W+8]=opcode, v[DATA_W+7:DATA_W]=channel, v[WIDTH-1:0]=value.
//  Opcodes: 0 inc, 1 dec, 2 readGray, 3 writeGray, 4 readBin, 5 writeBin; others illegal.
//  State: per channel WIDTH-bit binary register bin[c]; gray view = bin ^ (bin >> 1).
//  Reset: all bin[c]=0, FIFO empty, request$enq__RDY=0 in reset cycle then 1,
//   indication$enq__ENA=0, indication$enq$v=0.
//  Accept: request$enq__RDY = !fifo_full (all opcodes, keeps replies ordered).
//  Transfer on cycle N (ENA&RDY): bin[c] updated at edge ending N, visible cycle N+1.
//  inc: bin+1; at all-ones -> 0 (SATURATE=0) or hold (SATURATE=1). dec: mirror at 0.
//  writeBin: bin=value. writeGray: bin = prefix-XOR decode of value (bin[i]=^g[W-1:i]).
//  readGray/readBin: reply pushed at edge ending N; header echoes opcode+channel,
//   payload = gray/bin value zero-extended to DATA_W. Reads see state before same-beat ops
//   only from earlier beats (one beat per cycle, no bypass hazard).
//  Write/inc/dec: no reply.
//  Error: opcode>5 or channel>=NUM_CNT -> no state change; reply opcode=8'hFF,
//   channel echoed, payload[7:0]=original opcode, rest 0.
//  Output: indication$enq__ENA = !fifo_empty & indication$enq__RDY; pop on ENA.
//   indication$enq$v = FIFO head, stable while not popped. Min request->reply latency 1 cycle.
//  FIFO: push+pop same cycle allowed at any occupancy other than full-with-push
//   (excluded by __RDY); count unchanged. Full -> __RDY=0 until a pop; pop frees slot,
//   __RDY=1 next cycle. Empty -> ENA=0 regardless of __RDY.
//  Pointers wrap modulo IND_DEPTH; occupancy counter log2(IND_DEPTH)+1 bits.
//  Reset mid-operation: any in-flight beat discarded, FIFO flushed, counters cleared
//   same edge; a request with ENA high during reset is ignored.
// TESTING
//  1 reset, writeBin ch2 v=5, readGray ch2 -> one reply op=2 ch=2 payload=7, 1 cycle later.
//  2 ch0 from 0: 16x inc, readBin -> 0 (SATURATE=0); same with SATURATE=1 -> 15;
//    dec at 0 -> 15 / 0 respectively.
//  3 writeGray ch1 v=4'b1101 then readBin ch1 -> 9; other channels stay 0 (isolation).
//  4 hold indication__RDY=0, issue 4 reads -> request__RDY=0 after 4th; 5th not accepted;
//    release -> 4 replies in issue order, __RDY rises cycle after first pop.
//  5 opcode 7 ch0 and opcode 2 ch=NUM_CNT -> two replies op=FF payload 7 / 2, state unchanged.
//  6 assert nRST with 3 replies queued -> ENA=0 next cycle, FIFO empty, all reads return 0.

Source files
------------

// File: rtl/gray_counter_bank.sv
// Bank of NUM_CNT binary/gray counters behind a single request port.
// Reads and errors are answered through an IND_DEPTH-entry reply FIFO.
module gray_counter_bank #(
  parameter int WIDTH     = 4,
  parameter int NUM_CNT   = 4,
  parameter int IND_DEPTH = 4,
  parameter int HDR_W     = 16,
  parameter int DATA_W    = 128,
  parameter int SATURATE  = 0
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    request_enq__ENA,
  input  logic [HDR_W+DATA_W-1:0] request_enq_v,
  output logic                    request_enq__RDY,
  output logic                    indication_enq__ENA,
  output logic [HDR_W+DATA_W-1:0] indication_enq_v,
  input  logic                    indication_enq__RDY
);

  localparam int MSG_W = HDR_W + DATA_W;
  localparam int PTR_W = $clog2(IND_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [7:0] OP_INC   = 8'd0;
  localparam logic [7:0] OP_DEC   = 8'd1;
  localparam logic [7:0] OP_RDGRY = 8'd2;
  localparam logic [7:0] OP_WRGRY = 8'd3;
  localparam logic [7:0] OP_RDBIN = 8'd4;
  localparam logic [7:0] OP_WRBIN = 8'd5;
  localparam logic [7:0] OP_ERR   = 8'hFF;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [MSG_W-1:0] msg_t;

  function automatic word_t bin_inc(input word_t b);
    if (SATURATE != 0 && b == '1) return b;
    return b + word_t'(1);
  endfunction

  function automatic word_t bin_dec(input word_t b);
    if (SATURATE != 0 && b == '0) return b;
    return b - word_t'(1);
  endfunction

  function automatic word_t gray_enc(input word_t b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all gray bits at or above it.
  function automatic word_t gray_dec(input word_t g);
    word_t b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic msg_t make_reply(input logic [7:0] op, input logic [7:0] ch,
                                      input logic [DATA_W-1:0] pl);
    return {HDR_W'({op, ch}), pl};
  endfunction

  word_t             bin_q [NUM_CNT];
  word_t             bin_d [NUM_CNT];
  msg_t              mem_q [IND_DEPTH];
  msg_t              mem_d [IND_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              vld_p0;
  logic [7:0]        op_p0;
  logic [7:0]        ch_p0;
  word_t             val_p0;
  word_t             cur_p0;
  logic              err_p0;
  logic              push;
  logic              pop;
  msg_t              reply;
  logic              fifo_empty;
  logic              fifo_full;
  logic              unused_req;

  // Stage p0: decode the accepted request beat.
  assign vld_p0 = request_enq__ENA & request_enq__RDY;
  assign op_p0  = request_enq_v[DATA_W+15 -: 8];
  assign ch_p0  = request_enq_v[DATA_W+7 -: 8];
  assign val_p0 = request_enq_v[WIDTH-1:0];
  assign err_p0 = (op_p0 > OP_WRBIN) || (int'(ch_p0) >= NUM_CNT);
  assign unused_req = ^request_enq_v;

  always_comb begin
    cur_p0 = '0;
    for (int c = 0; c < NUM_CNT; c++) begin
      if (ch_p0 == 8'(c)) cur_p0 = bin_q[c];
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CNT; c++) bin_d[c] = bin_q[c];
    if (vld_p0 && !err_p0) begin
      for (int c = 0; c < NUM_CNT; c++) begin
        if (ch_p0 == 8'(c)) begin
          case (op_p0)
            OP_INC:   bin_d[c] = bin_inc(bin_q[c]);
            OP_DEC:   bin_d[c] = bin_dec(bin_q[c]);
            OP_WRGRY: bin_d[c] = gray_dec(val_p0);
            OP_WRBIN: bin_d[c] = val_p0;
            default:  bin_d[c] = bin_q[c];
          endcase
        end
      end
    end
  end

  always_comb begin
    push  = 1'b0;
    reply = '0;
    if (vld_p0) begin
      if (err_p0) begin
        push  = 1'b1;
        reply = make_reply(OP_ERR, ch_p0, DATA_W'(op_p0));
      end else if (op_p0 == OP_RDGRY) begin
        push  = 1'b1;
        reply = make_reply(op_p0, ch_p0, DATA_W'(gray_enc(cur_p0)));
      end else if (op_p0 == OP_RDBIN) begin
        push  = 1'b1;
        reply = make_reply(op_p0, ch_p0, DATA_W'(cur_p0));
      end
    end
  end

  // Reply FIFO: every opcode is throttled on full so replies never reorder.
  assign fifo_empty          = (cnt_q == '0);
  assign fifo_full           = (cnt_q == CNT_W'(IND_DEPTH));
  assign request_enq__RDY    = !nRST && !fifo_full;
  assign pop                 = !nRST && !fifo_empty && indication_enq__RDY;
  assign indication_enq__ENA = pop;
  assign indication_enq_v    = (nRST || fifo_empty) ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    for (int i = 0; i < IND_DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = reply;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < IND_DEPTH; i++) mem_q[i] <= mem_d[i];
    if (nRST) begin
      for (int c = 0; c < NUM_CNT; c++) bin_q[c] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      for (int c = 0; c < NUM_CNT; c++) bin_q[c] <= bin_d[c];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_gray_counter_bank.sv
// Scoreboard bench: a wrapping and a saturating bank share one request stream;
// each has its own reference model and expected-reply queue.
module tb_gray_counter_bank;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_ena;
  logic [143:0] req_v;
  logic         ind_rdy;
  logic         req_rdy0, req_rdy1;
  logic         ind_ena0, ind_ena1;
  logic [143:0] ind_v0, ind_v1;

  int total = 0;
  int bad   = 0;

  logic [3:0]   m0 [4];
  logic [3:0]   m1 [4];
  logic [143:0] q0 [$];
  logic [143:0] q1 [$];

  always #5 clk = ~clk;

  gray_counter_bank #(.SATURATE(0)) dut0 (
    .CLK(clk), .nRST(rst),
    .request_enq__ENA(req_ena), .request_enq_v(req_v), .request_enq__RDY(req_rdy0),
    .indication_enq__ENA(ind_ena0), .indication_enq_v(ind_v0),
    .indication_enq__RDY(ind_rdy)
  );

  gray_counter_bank #(.SATURATE(1)) dut1 (
    .CLK(clk), .nRST(rst),
    .request_enq__ENA(req_ena), .request_enq_v(req_v), .request_enq__RDY(req_rdy1),
    .indication_enq__ENA(ind_ena1), .indication_enq_v(ind_v1),
    .indication_enq__RDY(ind_rdy)
  );

  function automatic logic [3:0] ref_gray(input logic [3:0] b);
    logic [3:0] g;
    g[3] = b[3];
    for (int i = 0; i < 3; i++) g[i] = b[i] ^ b[i+1];
    return g;
  endfunction

  function automatic logic [3:0] ref_ungray(input logic [3:0] g);
    return g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
  endfunction

  function automatic logic [143:0] mk(input logic [7:0] op, input logic [7:0] ch,
                                      input logic [127:0] pl);
    return {op, ch, pl};
  endfunction

  task automatic model_beat(input logic [7:0] op, input logic [7:0] ch, input logic [3:0] val);
    logic [1:0] c;
    c = ch[1:0];
    if (op > 8'd5 || ch >= 8'd4) begin
      q0.push_back(mk(8'hFF, ch, {120'b0, op}));
      q1.push_back(mk(8'hFF, ch, {120'b0, op}));
    end else begin
      case (op)
        8'd0: begin
          m0[c] = m0[c] + 4'd1;
          m1[c] = (m1[c] == 4'hF) ? 4'hF : m1[c] + 4'd1;
        end
        8'd1: begin
          m0[c] = m0[c] - 4'd1;
          m1[c] = (m1[c] == 4'h0) ? 4'h0 : m1[c] - 4'd1;
        end
        8'd2: begin
          q0.push_back(mk(op, ch, {124'b0, ref_gray(m0[c])}));
          q1.push_back(mk(op, ch, {124'b0, ref_gray(m1[c])}));
        end
        8'd3: begin
          m0[c] = ref_ungray(val);
          m1[c] = ref_ungray(val);
        end
        8'd4: begin
          q0.push_back(mk(op, ch, {124'b0, m0[c]}));
          q1.push_back(mk(op, ch, {124'b0, m1[c]}));
        end
        default: begin
          m0[c] = val;
          m1[c] = val;
        end
      endcase
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m0[i] = 4'h0;
      m1[i] = 4'h0;
    end
    q0.delete();
    q1.delete();
  endtask

  // One request beat; upper payload bits carry junk the DUT must ignore.
  task automatic send(input logic [7:0] op, input logic [7:0] ch, input logic [3:0] val);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!req_rdy0 && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!req_rdy0) begin
      total++; bad++;
      $display("FAIL send_timeout op=%0d ch=%0d rdy=%b required 1", op, ch, req_rdy0);
    end else begin
      req_v   = {op, ch, 124'($urandom), val};
      req_ena = 1'b1;
      model_beat(op, ch, val);
      @(posedge clk);
      #1;
      req_ena = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (q0.size() != 0 || q1.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d/%0d required 0/0", q0.size(), q1.size());
    end
  endtask

  // Scoreboard: every transferred reply must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (ind_ena0) begin
        total++;
        if (q0.size() == 0) begin
          bad++;
          $display("FAIL reply0_unexpected got=%h", ind_v0);
        end else begin
          logic [143:0] e;
          e = q0.pop_front();
          if (ind_v0 !== e) begin
            bad++;
            $display("FAIL reply0 got=%h required=%h", ind_v0, e);
          end
        end
      end
      if (ind_ena1) begin
        total++;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL reply1_unexpected got=%h", ind_v1);
        end else begin
          logic [143:0] e;
          e = q1.pop_front();
          if (ind_v1 !== e) begin
            bad++;
            $display("FAIL reply1 got=%h required=%h", ind_v1, e);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; req_ena = 1'b0; req_v = '0; ind_rdy = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (req_rdy0 !== 1'b0 || req_rdy1 !== 1'b0 || ind_ena0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_in rdy=%b/%b ena=%b required 0/0/0", req_rdy0, req_rdy1, ind_ena0);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    total++;
    if (req_rdy0 !== 1'b1 || ind_ena0 !== 1'b0 || ind_v0 !== '0) begin
      bad++;
      $display("FAIL reset_out rdy=%b ena=%b v=%h required 1/0/0", req_rdy0, ind_ena0, ind_v0);
    end
  endtask

  task automatic test_basic();
    send(8'd5, 8'd2, 4'd5);
    send(8'd2, 8'd2, 4'd0);
    @(negedge clk);
    total++;
    if (ind_ena0 !== 1'b1 || ind_v0 !== mk(8'd2, 8'd2, 128'd7)) begin
      bad++;
      $display("FAIL basic_latency ena=%b v=%h required 1/op2 ch2 7", ind_ena0, ind_v0);
    end
    drain();
  endtask

  task automatic test_saturate();
    repeat (16) send(8'd0, 8'd0, 4'd0);
    send(8'd4, 8'd0, 4'd0);
    send(8'd5, 8'd0, 4'd0);
    send(8'd1, 8'd0, 4'd0);
    send(8'd4, 8'd0, 4'd0);
    send(8'd2, 8'd0, 4'd0);
    drain();
  endtask

  task automatic test_gray_write();
    send(8'd3, 8'd1, 4'b1101);
    send(8'd4, 8'd1, 4'd0);
    send(8'd2, 8'd1, 4'd0);
    for (int c = 0; c < 4; c++) send(8'd4, 8'(c), 4'd0);
    for (int v = 0; v < 16; v += 5) begin
      send(8'd3, 8'd3, 4'(v));
      send(8'd4, 8'd3, 4'd0);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    ind_rdy = 1'b0;
    for (int c = 0; c < 4; c++) send(8'd4, 8'(c), 4'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (req_rdy0 !== 1'b0 || req_rdy1 !== 1'b0 || ind_ena0 !== 1'b0) begin
        bad++;
        $display("FAIL full_hold rdy=%b/%b ena=%b required 0/0/0", req_rdy0, req_rdy1, ind_ena0);
      end
    end
    @(posedge clk); #1; ind_rdy = 1'b1;
    @(negedge clk);
    total++;
    if (ind_ena0 !== 1'b1 || req_rdy0 !== 1'b0) begin
      bad++;
      $display("FAIL first_pop ena=%b rdy=%b required 1/0", ind_ena0, req_rdy0);
    end
    @(negedge clk);
    total++;
    if (req_rdy0 !== 1'b1) begin
      bad++;
      $display("FAIL rdy_after_pop rdy=%b required 1", req_rdy0);
    end
    drain();
  endtask

  task automatic test_error();
    send(8'd7, 8'd0, 4'd3);
    send(8'd2, 8'd4, 4'd0);
    send(8'd5, 8'd9, 4'd6);
    for (int c = 0; c < 4; c++) send(8'd4, 8'(c), 4'd0);
    drain();
  endtask

  task automatic test_reset_mid();
    ind_rdy = 1'b0;
    for (int c = 0; c < 3; c++) send(8'd2, 8'(c), 4'd0);
    @(negedge clk);
    rst = 1'b1; ind_rdy = 1'b1;
    req_v = {8'd5, 8'd3, 124'b0, 4'd5}; req_ena = 1'b1;
    model_clear();
    #1;
    total++;
    if (req_rdy0 !== 1'b0 || ind_ena0 !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_cycle rdy=%b ena=%b required 0/0", req_rdy0, ind_ena0);
    end
    @(posedge clk); #1; rst = 1'b0; req_ena = 1'b0;
    @(negedge clk);
    total++;
    if (ind_ena0 !== 1'b0 || ind_v0 !== '0 || req_rdy0 !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_after ena=%b v=%h rdy=%b required 0/0/1", ind_ena0, ind_v0, req_rdy0);
    end
    for (int c = 0; c < 4; c++) send(8'd4, 8'(c), 4'd0);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_gray_write();
    test_back_to_back();
    test_error();
    test_reset_mid();
    repeat (3) @(negedge clk);
    total++;
    if (ind_ena0 !== 1'b0 || ind_ena1 !== 1'b0) begin
      bad++;
      $display("FAIL idle_end ena=%b/%b required 0/0", ind_ena0, ind_ena1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
